// File: rtl/count_seq_checker.sv
// Receive-side checker for a wrap-around count stream: locks onto LOW..HIGH
// sequencing, flags deviations once locked, and keeps saturating wrap/error statistics.
module count_seq_checker #(
   parameter int WIDTH    = 4,
   parameter int LOW      = 5,
   parameter int HIGH     = 15,
   parameter int LOCK_RUN = 3,
   parameter int STAT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              count_valid,
   input  logic              clear_stats,
   output logic              locked,
   output logic              seq_error,
   output logic              wrap_pulse,
   output logic [WIDTH-1:0]  expected,
   output logic [STAT_W-1:0] wrap_count,
   output logic [STAT_W-1:0] error_count
);

   localparam int                RUN_W      = 4;
   localparam logic [WIDTH-1:0]  LOW_V      = WIDTH'(LOW);
   localparam logic [WIDTH-1:0]  HIGH_V     = WIDTH'(HIGH);
   localparam logic [WIDTH-1:0]  ONE_V      = WIDTH'(1);
   localparam logic [RUN_W-1:0]  RUN_ZERO   = {RUN_W{1'b0}};
   localparam logic [RUN_W-1:0]  RUN_ONE    = RUN_W'(1);
   localparam logic [RUN_W-1:0]  LOCK_RUN_V = RUN_W'(LOCK_RUN);
   localparam logic [STAT_W-1:0] STAT_ZERO  = {STAT_W{1'b0}};
   localparam logic [STAT_W-1:0] STAT_ONE   = STAT_W'(1);
   localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

   typedef enum logic [1:0] {
      S_UNLOCKED = 2'd0,
      S_LOCKING  = 2'd1,
      S_LOCKED   = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      if (x == HIGH_V) begin
         r = LOW_V;
      end else begin
         r = x + ONE_V;
      end
      return r;
   endfunction

   function automatic logic in_range(input logic [WIDTH-1:0] x);
      return (x >= LOW_V) && (x <= HIGH_V);
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
      logic [STAT_W-1:0] r;
      if (c == STAT_MAX) begin
         r = c;
      end else begin
         r = c + STAT_ONE;
      end
      return r;
   endfunction

   state_t            state_r, state_nx_s;
   logic [WIDTH-1:0]  last_r, last_nx_s;
   logic [RUN_W-1:0]  run_r, run_nx_s;
   logic              locked_r, seq_error_r, wrap_pulse_r;
   logic [WIDTH-1:0]  expected_r;
   logic [STAT_W-1:0] wrap_count_r, error_count_r;
   logic [STAT_W-1:0] wrap_count_nx_s, error_count_nx_s;
   logic              err_nx_s, wrap_nx_s;
   logic              match_s, range_s;

   assign match_s = (count_in == succ(last_r));
   assign range_s = in_range(count_in);

   // Next-state, sequence tracking and pulse decode for one sampled count.
   always_comb begin
      state_nx_s = state_r;
      last_nx_s  = last_r;
      run_nx_s   = run_r;
      err_nx_s   = 1'b0;
      wrap_nx_s  = 1'b0;
      if (count_valid) begin
         case (state_r)
            S_UNLOCKED: begin
               if (range_s) begin
                  last_nx_s  = count_in;
                  run_nx_s   = RUN_ZERO;
                  state_nx_s = S_LOCKING;
               end else begin
                  state_nx_s = S_UNLOCKED;
               end
            end
            S_LOCKING: begin
               if (match_s) begin
                  last_nx_s = count_in;
                  run_nx_s  = run_r + RUN_ONE;
                  if ((run_r + RUN_ONE) == LOCK_RUN_V) begin
                     state_nx_s = S_LOCKED;
                  end else begin
                     state_nx_s = S_LOCKING;
                  end
               end else if (range_s) begin
                  last_nx_s  = count_in;
                  run_nx_s   = RUN_ZERO;
                  state_nx_s = S_LOCKING;
               end else begin
                  state_nx_s = S_UNLOCKED;
               end
            end
            S_LOCKED: begin
               if (match_s) begin
                  last_nx_s  = count_in;
                  state_nx_s = S_LOCKED;
                  wrap_nx_s  = (last_r == HIGH_V);
               end else begin
                  err_nx_s = 1'b1;
                  if (range_s) begin
                     last_nx_s  = count_in;
                     run_nx_s   = RUN_ZERO;
                     state_nx_s = S_LOCKING;
                  end else begin
                     state_nx_s = S_UNLOCKED;
                  end
               end
            end
            default: begin
               state_nx_s = S_UNLOCKED;
               last_nx_s  = HIGH_V;
               run_nx_s   = RUN_ZERO;
            end
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Saturating statistics; a coincident clear beats an increment.
   always_comb begin
      wrap_count_nx_s  = wrap_count_r;
      error_count_nx_s = error_count_r;
      if (clear_stats) begin
         wrap_count_nx_s  = STAT_ZERO;
         error_count_nx_s = STAT_ZERO;
      end else begin
         if (wrap_nx_s) begin
            wrap_count_nx_s = sat_inc(wrap_count_r);
         end else begin
            wrap_count_nx_s = wrap_count_r;
         end
         if (err_nx_s) begin
            error_count_nx_s = sat_inc(error_count_r);
         end else begin
            error_count_nx_s = error_count_r;
         end
      end
   end

   // State and registered outputs; reset parks on last = HIGH so expected = LOW.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= S_UNLOCKED;
         last_r        <= HIGH_V;
         run_r         <= RUN_ZERO;
         locked_r      <= 1'b0;
         seq_error_r   <= 1'b0;
         wrap_pulse_r  <= 1'b0;
         expected_r    <= LOW_V;
         wrap_count_r  <= STAT_ZERO;
         error_count_r <= STAT_ZERO;
      end else begin
         state_r       <= state_nx_s;
         last_r        <= last_nx_s;
         run_r         <= run_nx_s;
         locked_r      <= (state_nx_s == S_LOCKED);
         seq_error_r   <= err_nx_s;
         wrap_pulse_r  <= wrap_nx_s;
         expected_r    <= succ(last_nx_s);
         wrap_count_r  <= wrap_count_nx_s;
         error_count_r <= error_count_nx_s;
      end
   end

   assign locked      = locked_r;
   assign seq_error   = seq_error_r;
   assign wrap_pulse  = wrap_pulse_r;
   assign expected    = expected_r;
   assign wrap_count  = wrap_count_r;
   assign error_count = error_count_r;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares the registered outputs.
module tb_count_seq_checker;

   logic       clk;
   logic       reset;
   logic [3:0] count_in;
   logic       count_valid;
   logic       clear_stats;
   logic       locked;
   logic       seq_error;
   logic       wrap_pulse;
   logic [3:0] expected;
   logic [7:0] wrap_count;
   logic [7:0] error_count;

   typedef struct {
      logic       l;
      logic       e;
      logic       w;
      logic [3:0] x;
      logic [7:0] wc;
      logic [7:0] ec;
   } exp_t;

   exp_t q[$];
   int   n_vec;
   int   n_bad;

   count_seq_checker #(
      .WIDTH(4), .LOW(5), .HIGH(15), .LOCK_RUN(3), .STAT_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .count_in(count_in),
      .count_valid(count_valid),
      .clear_stats(clear_stats),
      .locked(locked),
      .seq_error(seq_error),
      .wrap_pulse(wrap_pulse),
      .expected(expected),
      .wrap_count(wrap_count),
      .error_count(error_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] nxt(input logic [3:0] x);
      logic [3:0] r;
      if (x == 4'd15) r = 4'd5;
      else r = x + 4'd1;
      return r;
   endfunction

   task automatic step(input logic v, input logic [3:0] c, input logic clr, input logic rst,
                       input logic el, input logic ee, input logic ew, input logic [3:0] ex,
                       input logic [7:0] ewc, input logic [7:0] eec);
      exp_t t;
      @(negedge clk);
      count_valid = v;
      count_in    = c;
      clear_stats = clr;
      reset       = rst;
      @(posedge clk);
      #1;
      t.l = el; t.e = ee; t.w = ew; t.x = ex; t.wc = ewc; t.ec = eec;
      q.push_back(t);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at vector %0d: got %0d, expected %0d", name, n_vec, act, req);
      end
   endtask

   // Monitor: every cycle with a pending expectation, compare all outputs.
   always @(negedge clk) begin
      exp_t t;
      if (q.size() > 0) begin
         t = q.pop_front();
         n_vec++;
         chk("locked",      {7'd0, locked},     {7'd0, t.l});
         chk("seq_error",   {7'd0, seq_error},  {7'd0, t.e});
         chk("wrap_pulse",  {7'd0, wrap_pulse}, {7'd0, t.w});
         chk("expected",    {4'd0, expected},   {4'd0, t.x});
         chk("wrap_count",  wrap_count,         t.wc);
         chk("error_count", error_count,        t.ec);
      end
   end

   logic [3:0] last_v;
   logic [3:0] v;
   logic [7:0] ec_e;

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      count_valid = 1'b0;
      count_in = 4'd0;
      clear_stats = 1'b0;

      //    v     cin  clr   rst   lock  err   wrap  exp   wc    ec
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 8'd0, 8'd0);
      // acquisition 5,6,7,8
      step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 8'd0, 8'd0);
      step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 8'd0, 8'd0);
      step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 8'd0, 8'd0);
      step(1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 8'd0, 8'd0);
      // locked at 9, inject 11, relock on 12,13,14
      step(1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd10, 8'd0, 8'd0);
      step(1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd12, 8'd0, 8'd1);
      step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd13, 8'd0, 8'd1);
      step(1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd14, 8'd0, 8'd1);
      step(1'b1, 4'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 8'd0, 8'd1);
      // wrap 15 -> 5 -> 6
      step(1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 8'd0, 8'd1);
      step(1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 8'd1, 8'd1);
      step(1'b1, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 8'd1, 8'd1);
      // gaps with changing count_in, then 7, then a repeated 7
      step(1'b0, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 8'd1, 8'd1);
      step(1'b0, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 8'd1, 8'd1);
      step(1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 8'd1, 8'd1);
      step(1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 8'd1, 8'd2);
      step(1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 8'd1, 8'd2);
      step(1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 8'd1, 8'd2);
      step(1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd11, 8'd1, 8'd2);
      // out-of-range 3 while locked, then 2 while unlocked
      step(1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd11, 8'd1, 8'd3);
      step(1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 8'd1, 8'd3);
      // clear_stats without valid
      step(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 8'd0, 8'd0);
      // LOCKING: out-of-range drops to UNLOCKED, in-range mismatch restarts run
      step(1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 8'd0, 8'd0);
      step(1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 8'd0, 8'd0);
      step(1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 8'd0, 8'd0);
      step(1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 8'd0, 8'd0);
      step(1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 8'd0, 8'd0);
      step(1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 8'd0, 8'd0);
      step(1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12, 8'd0, 8'd0);
      step(1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd13, 8'd0, 8'd0);

      // 256 repeat-errors, each followed by a 3-sample relock; count saturates at 255
      last_v = 4'd12;
      ec_e   = 8'd0;
      for (int i = 0; i < 256; i++) begin
         if (ec_e != 8'd255) ec_e = ec_e + 8'd1;
         step(1'b1, last_v, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, nxt(last_v), 8'd0, ec_e);
         v = nxt(last_v);
         step(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nxt(v), 8'd0, ec_e);
         v = nxt(v);
         step(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nxt(v), 8'd0, ec_e);
         v = nxt(v);
         step(1'b1, v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, nxt(v), 8'd0, ec_e);
         last_v = v;
      end

      // clear coinciding with an error: counter reads 0, pulse still fires
      step(1'b1, last_v, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, nxt(last_v), 8'd0, 8'd0);
      v = nxt(last_v);
      step(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nxt(v), 8'd0, 8'd0);
      v = nxt(v);
      step(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nxt(v), 8'd0, 8'd0);
      v = nxt(v);
      step(1'b1, v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, nxt(v), 8'd0, 8'd0);
      // reset mid-lock with a would-be error sample and clear also present
      step(1'b1, v, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 8'd0, 8'd0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 8'd0, 8'd0);
      step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 8'd0, 8'd0);

      repeat (3) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
